// File: rtl/dbg_breakpoints_if.sv
`default_nettype none
// ============================================================================
// Module   : dbg_breakpoints_if
// Purpose  : Control, compare and read-back bundle of the breakpoint unit.
//            Watchpoint signals exist only when BP_WATCH_EN is defined.
// Revision : 1.0
// ============================================================================
interface dbg_breakpoints_if #(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 16,
  parameter int SW_W   = 8
);
  localparam int BYTES = (ADDR_W + SW_W - 1) / SW_W;
  localparam int ID_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int LB_W  = $clog2(BYTES) + 1;

  logic              load;
  logic [SW_W-1:0]   sw;
  logic              clr;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              cont;
  logic [ID_W-1:0]   dbg_sel;
  logic              hit;
  logic [ID_W-1:0]   hit_id;
  logic [ID_W-1:0]   load_slot;
  logic [LB_W-1:0]   load_byte;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_valid;
`ifdef BP_WATCH_EN
  logic [ADDR_W-1:0] mem_a;
  logic              mem_rd;
  logic              mem_wr;
  logic [1:0]        hit_kind;
`endif

  modport master (
    output load, sw, clr, pc, pc_valid, cont, dbg_sel,
`ifdef BP_WATCH_EN
    output mem_a, mem_rd, mem_wr,
    input  hit_kind,
`endif
    input  hit, hit_id, load_slot, load_byte, dbg_addr, dbg_valid
  );

  modport slave (
    input  load, sw, clr, pc, pc_valid, cont, dbg_sel,
`ifdef BP_WATCH_EN
    input  mem_a, mem_rd, mem_wr,
    output hit_kind,
`endif
    output hit, hit_id, load_slot, load_byte, dbg_addr, dbg_valid
  );
endinterface
`default_nettype wire

// File: rtl/dbg_breakpoints.sv
`default_nettype none
// ============================================================================
// Module   : dbg_breakpoints
// Purpose  : NUM_BP switch-loaded breakpoint slots with sticky halt request.
//            Define BP_WATCH_EN to add read/write data watchpoints.
// Revision : 1.0
// ============================================================================
module dbg_breakpoints #(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 16,
  parameter int SW_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  dbg_breakpoints_if.slave bp_io
);
  localparam int BYTES = (ADDR_W + SW_W - 1) / SW_W;
  localparam int ID_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int LB_W  = $clog2(BYTES) + 1;
  localparam logic [1:0] MODE_EXEC  = 2'b01;
`ifdef BP_WATCH_EN
  localparam logic [1:0] MODE_READ  = 2'b10;
  localparam logic [1:0] MODE_WRITE = 2'b11;
`endif

  typedef enum logic [1:0] {SEQ_B0 = 2'd0, SEQ_BN = 2'd1, SEQ_BM = 2'd2} seq_e;

  logic [NUM_BP-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_BP-1:0]             valid_q, valid_d;
  logic [ID_W-1:0]               load_slot_q, load_slot_d;
  logic [LB_W-1:0]               load_byte_q, load_byte_d;
  logic                          hit_q, hit_d;
  logic [ID_W-1:0]               hit_id_q, hit_id_d;
`ifdef BP_WATCH_EN
  logic [NUM_BP-1:0][1:0]        mode_q, mode_d;
  logic [1:0]                    hit_kind_q, hit_kind_d;
  logic [1:0]                    kind_w;
`endif

  seq_e              seq_w;
  logic              last_w;
  logic [NUM_BP-1:0] match_w;
  logic              any_w;
  logic [ID_W-1:0]   first_w;

  // The load pointer is the sequencer state; classify it into its step kind.
  always_comb begin
    seq_w = SEQ_BN;
    if (load_byte_q == '0) seq_w = SEQ_B0;
`ifdef BP_WATCH_EN
    if (load_byte_q == LB_W'(BYTES)) seq_w = SEQ_BM;
    last_w = (seq_w == SEQ_BM);
`else
    last_w = (load_byte_q == LB_W'(BYTES - 1));
`endif
  end

  always_comb begin
    addr_d      = addr_q;
    valid_d     = valid_q;
    load_slot_d = load_slot_q;
    load_byte_d = load_byte_q;
`ifdef BP_WATCH_EN
    mode_d      = mode_q;
`endif
    if (bp_io.clr) begin
      valid_d     = '0;
      load_slot_d = '0;
      load_byte_d = '0;
    end else if (bp_io.load) begin
      for (int s = 0; s < NUM_BP; s++) begin
        if (load_slot_q == ID_W'(s)) begin
          for (int b = 0; b < ADDR_W; b++) begin
            if (b / SW_W == int'(load_byte_q)) addr_d[s][b] = bp_io.sw[b % SW_W];
          end
          if (seq_w == SEQ_B0) valid_d[s] = 1'b0;
`ifdef BP_WATCH_EN
          if (seq_w == SEQ_BM) begin
            mode_d[s]  = bp_io.sw[1:0];
            valid_d[s] = |bp_io.sw[1:0];
          end
`else
          if (last_w) valid_d[s] = 1'b1;
`endif
        end
      end
      if (last_w) begin
        load_byte_d = '0;
        load_slot_d = (load_slot_q == ID_W'(NUM_BP - 1)) ? '0 : load_slot_q + ID_W'(1);
      end else begin
        load_byte_d = load_byte_q + LB_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_BP; i++) begin : g_slot
    logic pc_hit;
    assign pc_hit = bp_io.pc_valid && (bp_io.pc == addr_q[i]);
`ifdef BP_WATCH_EN
    logic mem_hit;
    assign mem_hit = (bp_io.mem_a == addr_q[i]) &&
                     ((mode_q[i] == MODE_READ  && bp_io.mem_rd) ||
                      (mode_q[i] == MODE_WRITE && bp_io.mem_wr));
    assign match_w[i] = valid_q[i] && ((mode_q[i] == MODE_EXEC && pc_hit) || mem_hit);
`else
    assign match_w[i] = valid_q[i] && pc_hit;
`endif
  end

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    any_w   = 1'b0;
    first_w = '0;
`ifdef BP_WATCH_EN
    kind_w  = MODE_EXEC;
`endif
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (match_w[i]) begin
        any_w   = 1'b1;
        first_w = ID_W'(i);
`ifdef BP_WATCH_EN
        kind_w  = mode_q[i];
`endif
      end
    end
  end

  always_comb begin
    hit_d    = hit_q;
    hit_id_d = hit_id_q;
`ifdef BP_WATCH_EN
    hit_kind_d = hit_kind_q;
`endif
    if (any_w && (!hit_q || bp_io.cont)) begin
      hit_d    = 1'b1;
      hit_id_d = first_w;
`ifdef BP_WATCH_EN
      hit_kind_d = kind_w;
`endif
    end else if (bp_io.cont) begin
      hit_d = 1'b0;
    end
  end

  always_comb begin
    bp_io.dbg_addr  = '1;
    bp_io.dbg_valid = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_io.dbg_sel == ID_W'(i)) begin
        bp_io.dbg_addr  = addr_q[i];
        bp_io.dbg_valid = valid_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '1;
      valid_q     <= '0;
      load_slot_q <= '0;
      load_byte_q <= '0;
      hit_q       <= 1'b0;
      hit_id_q    <= '0;
`ifdef BP_WATCH_EN
      mode_q      <= {NUM_BP{MODE_EXEC}};
      hit_kind_q  <= '0;
`endif
    end else begin
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      load_slot_q <= load_slot_d;
      load_byte_q <= load_byte_d;
      hit_q       <= hit_d;
      hit_id_q    <= hit_id_d;
`ifdef BP_WATCH_EN
      mode_q      <= mode_d;
      hit_kind_q  <= hit_kind_d;
`endif
    end
  end

  assign bp_io.hit       = hit_q;
  assign bp_io.hit_id    = hit_id_q;
  assign bp_io.load_slot = load_slot_q;
  assign bp_io.load_byte = load_byte_q;
`ifdef BP_WATCH_EN
  assign bp_io.hit_kind  = hit_kind_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_dbg_breakpoints.sv
`default_nettype none
// Bench for dbg_breakpoints: vector table, corner sequences and a randomized
// run against an array-based slot model.
module tb_dbg_breakpoints;
  localparam int NUM_BP = 4;
  localparam int ADDR_W = 16;
  localparam int SW_W   = 8;
  localparam int BYTES  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbg_breakpoints_if #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W), .SW_W(SW_W)) bp ();
  dbg_breakpoints #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W), .SW_W(SW_W)) dut (
    .clk(clk), .rst(rst), .bp_io(bp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit use_model = 1'b1;

  int m_addr [NUM_BP];
  bit m_valid[NUM_BP];
  int m_slot, m_byte, m_id;
  bit m_hit;

  typedef struct {
    bit ld; logic [7:0] sw; bit clr; logic [15:0] pc; bit pcv; bit cont; logic [1:0] sel;
    bit e_hit; logic [1:0] e_id; logic [1:0] e_slot; logic [1:0] e_byte;
    logic [15:0] e_addr; bit e_valid;
  } vec_t;
  vec_t tbl[21];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit ld, input logic [7:0] sw, input bit clr,
                       input logic [15:0] pc, input bit pcv, input bit cont,
                       input logic [1:0] sel);
    bp.load = ld; bp.sw = sw; bp.clr = clr; bp.pc = pc;
    bp.pc_valid = pcv; bp.cont = cont; bp.dbg_sel = sel;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_BP; i++) begin
      m_addr[i] = 32'hFFFF; m_valid[i] = 1'b0;
    end
    m_slot = 0; m_byte = 0; m_hit = 1'b0; m_id = 0;
  endtask

  // Applies one clock edge of the rules to the model, using pre-edge state.
  task automatic model_step();
    int mi, sh;
    mi = -1;
    for (int i = 0; i < NUM_BP; i++)
      if (mi < 0 && m_valid[i] && bp.pc_valid && int'(bp.pc) == m_addr[i]) mi = i;
    if (mi >= 0 && (!m_hit || bp.cont)) begin
      m_hit = 1'b1; m_id = mi;
    end else if (bp.cont) begin
      m_hit = 1'b0;
    end
    if (bp.clr) begin
      for (int i = 0; i < NUM_BP; i++) m_valid[i] = 1'b0;
      m_slot = 0; m_byte = 0;
    end else if (bp.load) begin
      sh = m_byte * SW_W;
      m_addr[m_slot] = ((m_addr[m_slot] & ~(32'hFF << sh)) | (int'(bp.sw) << sh)) & 32'hFFFF;
      if (m_byte == 0) m_valid[m_slot] = 1'b0;
      if (m_byte == BYTES - 1) begin
        m_valid[m_slot] = 1'b1;
        m_byte = 0;
        m_slot = (m_slot + 1) % NUM_BP;
      end else begin
        m_byte++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    #1;
    if (use_model) begin
      check("model hit", bp.hit, m_hit);
      check("model hit_id", bp.hit_id, m_id);
      check("model load_slot", bp.load_slot, m_slot);
      check("model load_byte", bp.load_byte, m_byte);
      check("model dbg_addr", bp.dbg_addr, m_addr[bp.dbg_sel]);
      check("model dbg_valid", bp.dbg_valid, m_valid[bp.dbg_sel]);
    end
  endtask

  initial begin
    // ld sw clr pc pcv cont sel | hit id slot byte addr valid
    tbl[0]  = '{0, 8'h00, 0, 16'hFFFF, 1, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 0};
    tbl[1]  = '{0, 8'h00, 0, 16'hFFFF, 1, 0, 2'd1, 0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 0};
    tbl[2]  = '{0, 8'h00, 0, 16'hFFFF, 1, 0, 2'd2, 0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 0};
    tbl[3]  = '{0, 8'h00, 0, 16'hFFFF, 1, 0, 2'd3, 0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 0};
    tbl[4]  = '{1, 8'h50, 0, 16'h0000, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 16'hFF50, 0};
    tbl[5]  = '{1, 8'h01, 0, 16'h0000, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd0, 16'h0150, 1};
    tbl[6]  = '{0, 8'h00, 0, 16'h0150, 1, 0, 2'd0, 1, 2'd0, 2'd1, 2'd0, 16'h0150, 1};
    tbl[7]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 2'd0, 0, 2'd0, 2'd1, 2'd0, 16'h0150, 1};
    tbl[8]  = '{0, 8'h00, 1, 16'h0000, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 16'h0150, 0};
    tbl[9]  = '{1, 8'h00, 0, 16'h0000, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 16'h0100, 0};
    tbl[10] = '{1, 8'h02, 0, 16'h0000, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd0, 16'h0200, 1};
    tbl[11] = '{1, 8'h00, 0, 16'h0000, 0, 0, 2'd1, 0, 2'd0, 2'd1, 2'd1, 16'hFF00, 0};
    tbl[12] = '{1, 8'h03, 0, 16'h0000, 0, 0, 2'd1, 0, 2'd0, 2'd2, 2'd0, 16'h0300, 1};
    tbl[13] = '{1, 8'h00, 0, 16'h0000, 0, 0, 2'd2, 0, 2'd0, 2'd2, 2'd1, 16'hFF00, 0};
    tbl[14] = '{1, 8'h02, 0, 16'h0000, 0, 0, 2'd2, 0, 2'd0, 2'd3, 2'd0, 16'h0200, 1};
    tbl[15] = '{0, 8'h00, 0, 16'h0200, 1, 0, 2'd0, 1, 2'd0, 2'd3, 2'd0, 16'h0200, 1};
    tbl[16] = '{0, 8'h00, 0, 16'h0300, 1, 0, 2'd0, 1, 2'd0, 2'd3, 2'd0, 16'h0200, 1};
    tbl[17] = '{0, 8'h00, 0, 16'h0300, 1, 1, 2'd0, 1, 2'd1, 2'd3, 2'd0, 16'h0200, 1};
    tbl[18] = '{0, 8'h00, 0, 16'h0000, 0, 1, 2'd0, 0, 2'd1, 2'd3, 2'd0, 16'h0200, 1};
    tbl[19] = '{1, 8'hAA, 1, 16'h0000, 0, 0, 2'd0, 0, 2'd1, 2'd0, 2'd0, 16'h0200, 0};
    tbl[20] = '{0, 8'h00, 0, 16'h0200, 1, 0, 2'd0, 0, 2'd1, 2'd0, 2'd0, 16'h0200, 0};

    drive(0, 8'h00, 0, 16'h0000, 0, 0, 2'd0);
`ifdef BP_WATCH_EN
    bp.mem_a = '0; bp.mem_rd = 1'b0; bp.mem_wr = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset hit", bp.hit, 0);
    check("reset hit_id", bp.hit_id, 0);
    check("reset load_slot", bp.load_slot, 0);
    check("reset load_byte", bp.load_byte, 0);
    for (int s = 0; s < NUM_BP; s++) begin
      bp.dbg_sel = 2'(s);
      #1;
      check($sformatf("reset dbg_addr[%0d]", s), bp.dbg_addr, 16'hFFFF);
      check($sformatf("reset dbg_valid[%0d]", s), bp.dbg_valid, 0);
    end
    rst = 1'b0;
    model_reset();

`ifdef BP_WATCH_EN
    use_model = 1'b0;
    drive(1, 8'h00, 0, 16'h0000, 0, 0, 2'd0); tick();
    drive(1, 8'hC0, 0, 16'h0000, 0, 0, 2'd0); tick();
    drive(1, 8'h03, 0, 16'h0000, 0, 0, 2'd0); tick();
    check("watch dbg_addr", bp.dbg_addr, 16'hC000);
    check("watch dbg_valid", bp.dbg_valid, 1);
    drive(0, 8'h00, 0, 16'hC000, 1, 0, 2'd0);
    bp.mem_a = 16'hC000; bp.mem_rd = 1'b1; tick();
    check("watch rd no hit", bp.hit, 0);
    bp.mem_rd = 1'b0; bp.mem_wr = 1'b1; tick();
    check("watch wr hit", bp.hit, 1);
    check("watch hit_kind", bp.hit_kind, 2'b11);
    bp.mem_wr = 1'b0;
`else
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].ld, tbl[i].sw, tbl[i].clr, tbl[i].pc, tbl[i].pcv, tbl[i].cont, tbl[i].sel);
      tick();
      check($sformatf("row%0d hit", i), bp.hit, tbl[i].e_hit);
      check($sformatf("row%0d hit_id", i), bp.hit_id, tbl[i].e_id);
      check($sformatf("row%0d load_slot", i), bp.load_slot, tbl[i].e_slot);
      check($sformatf("row%0d load_byte", i), bp.load_byte, tbl[i].e_byte);
      check($sformatf("row%0d dbg_addr", i), bp.dbg_addr, tbl[i].e_addr);
      check($sformatf("row%0d dbg_valid", i), bp.dbg_valid, tbl[i].e_valid);
    end

    // Four full loads wrap the slot pointer; a lone byte then disarms slot 0.
    for (int s = 0; s < NUM_BP; s++) begin
      drive(1, 8'(s), 0, 16'h0000, 0, 0, 2'd0); tick();
      drive(1, 8'h10, 0, 16'h0000, 0, 0, 2'd0); tick();
    end
    check("wrap load_slot", bp.load_slot, 0);
    check("wrap load_byte", bp.load_byte, 0);
    drive(1, 8'hAA, 0, 16'h0000, 0, 0, 2'd0); tick();
    check("partial load_byte", bp.load_byte, 1);
    check("partial dbg_addr", bp.dbg_addr, 16'h10AA);
    check("partial dbg_valid", bp.dbg_valid, 0);
    drive(0, 8'h00, 0, 16'h1000, 1, 0, 2'd0); tick();
    check("old slot0 no hit", bp.hit, 0);
    drive(0, 8'h00, 0, 16'h1003, 1, 0, 2'd3); tick();
    check("slot3 hit", bp.hit, 1);
    check("slot3 hit_id", bp.hit_id, 3);
    drive(0, 8'h00, 0, 16'h0000, 0, 1, 2'd0); tick();
    check("cont clears hit", bp.hit, 0);
    // Arming edge and fetch in the same cycle: the match appears one cycle later.
    drive(1, 8'h20, 0, 16'h20AA, 1, 0, 2'd0); tick();
    check("arm edge no hit", bp.hit, 0);
    drive(0, 8'h00, 0, 16'h20AA, 1, 0, 2'd0); tick();
    check("armed next cycle hit", bp.hit, 1);
    check("armed next cycle hit_id", bp.hit_id, 0);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) == 0, 8'($urandom_range(0, 3)),
            $urandom_range(0, 39) == 0,
            {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)));
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
